// File: rtl/lpc_pkg.sv
// Shared constants, types and helpers for the LPC synthesis decoder.
// Contents: Q-format constants, FSM state enum, register map, LFSR seed,
//           STATUS register layout, 36-bit -> 16-bit saturation helper.
package lpc_pkg;

  localparam int unsigned DW          = 16;
  localparam int unsigned ACC_W       = 36;
  localparam int unsigned COEF_FRAC   = 12;
  localparam int unsigned ORDER       = 10;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned PITCH_MIN   = 20;
  localparam int unsigned NOISE_SHIFT = 3;

  localparam logic signed [DW-1:0] ONE_Q12    = 16'sd4096;
  localparam logic        [DW-1:0] REG_GAIN   = 16'd0;
  localparam logic        [DW-1:0] REG_STATUS = 16'd1;
  localparam logic        [DW-1:0] LFSR_SEED  = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXCITE,
    ST_MAC,
    ST_SAT,
    ST_DEEMPH,
    ST_OUT
  } state_e;

  typedef struct packed {
    logic [12:0] rsvd;
    logic        overrun;
    logic        busy;
    logic        voiced_active;
  } status_t;

  // Clamp a wide signed value into the 16-bit sample range.
  function automatic logic signed [DW-1:0] sat16(input logic signed [ACC_W-1:0] x);
    if (x > ACC_W'(32767))
      return 16'sh7FFF;
    else if (x < ACC_W'(-32768))
      return 16'sh8000;
    else
      return x[DW-1:0];
  endfunction

endpackage

// File: rtl/lpc_excitation_gen.sv
// Excitation source: pitch-period impulse train (voiced) or LFSR noise (unvoiced).
// Ports: clk, rst (async active-low), step (one pulse per sample),
//        voiced / freq_count (active frame parameters), gain (GAIN register),
//        e (signed excitation, valid the cycle after step).
module lpc_excitation_gen
  import lpc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               voiced,
  input  logic [DW-1:0]      freq_count,
  input  logic [DW-1:0]      gain,
  output logic signed [DW-1:0] e
);

  logic [DW-1:0]         cnt;
  logic [DW-1:0]         lfsr;
  logic [DW-1:0]         period_c;
  logic                  lfsr_fb_c;
  logic signed [32:0]    noise_prod_c;
  logic signed [DW-1:0]  noise_c;
  logic signed [DW-1:0]  pulse_c;

  // Period clamp, LFSR feedback (taps 16,14,13,11), scaled noise and clamped impulse.
  always_comb begin
    period_c     = (freq_count < DW'(PITCH_MIN)) ? DW'(PITCH_MIN) : freq_count;
    lfsr_fb_c    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    noise_prod_c = 33'($signed(lfsr)) * $signed({17'b0, gain});
    noise_c      = DW'(noise_prod_c >>> (15 + NOISE_SHIFT));
    pulse_c      = gain[DW-1] ? 16'sh7FFF : $signed(gain);
  end

  // LFSR advances every sample; an unvoiced sample parks the counter at 0 so
  // the next voiced sample fires an impulse immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      lfsr <= LFSR_SEED;
      e    <= '0;
    end else if (step) begin
      lfsr <= {lfsr_fb_c, lfsr[DW-1:1]};
      if (voiced) begin
        if (cnt == '0) begin
          e   <= pulse_c;
          cnt <= period_c - DW'(1);
        end else begin
          e   <= '0;
          cnt <= cnt - DW'(1);
        end
      end else begin
        e   <= noise_c;
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lpc_synth.sv
// LPC decoder: excitation generation + 10th-order all-pole synthesis filter.
// One output sample per v strobe; sample latency v->yv is 13 clks.
// Optional build macro LPC_SYNTH_DEEMPH_EN adds a de-emphasis stage
// (d = y + (15*d_prev)>>>4, saturated) and raises latency to 14 clks.
// Ports: clk, rst (async active-low); A1..A10 Q3.12 coefficients, voiced,
//        freq_count, coef_v (frame load); v (sample strobe); y/yv (sample out);
//        Avalon-MM slave address/read/write/writedata/readdata
//        (0 = GAIN rw, 1 = STATUS ro {overrun, busy, voiced_active}).
module lpc_synth
  import lpc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] A1,
  input  logic signed [DW-1:0] A2,
  input  logic signed [DW-1:0] A3,
  input  logic signed [DW-1:0] A4,
  input  logic signed [DW-1:0] A5,
  input  logic signed [DW-1:0] A6,
  input  logic signed [DW-1:0] A7,
  input  logic signed [DW-1:0] A8,
  input  logic signed [DW-1:0] A9,
  input  logic signed [DW-1:0] A10,
  input  logic                 voiced,
  input  logic [DW-1:0]        freq_count,
  input  logic                 coef_v,
  input  logic                 v,
  output logic signed [DW-1:0] y,
  output logic                 yv,
  input  logic [DW-1:0]        address,
  input  logic                 read,
  input  logic                 write,
  input  logic [DW-1:0]        writedata,
  output logic [DW-1:0]        readdata
);

  state_e                  state, state_nx;
  logic [IDX_W-1:0]        mac_idx;
  logic signed [DW-1:0]    a_in   [ORDER];
  logic signed [DW-1:0]    a_pend [ORDER];
  logic signed [DW-1:0]    a_act  [ORDER];
  logic signed [DW-1:0]    hist   [ORDER];
  logic                    pend_voiced, act_voiced;
  logic [DW-1:0]           pend_fc, act_fc;
  logic [DW-1:0]           gain;
  logic                    overrun;
  logic signed [DW-1:0]    e;
  logic signed [ACC_W-1:0] acc;
  logic signed [DW-1:0]    y_syn;

  logic                    start_c, step_c, mac_c, out_c, drop_c, yv_set_c;
  status_t                 status_c;
  logic signed [31:0]      prod_c;
  logic signed [ACC_W-1:0] acc_base_c, acc_nx_c, round_c;
  logic signed [DW-1:0]    sat_val_c, y_out_c;

  assign a_in[0] = A1;
  assign a_in[1] = A2;
  assign a_in[2] = A3;
  assign a_in[3] = A4;
  assign a_in[4] = A5;
  assign a_in[5] = A6;
  assign a_in[6] = A7;
  assign a_in[7] = A8;
  assign a_in[8] = A9;
  assign a_in[9] = A10;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (v) state_nx = ST_EXCITE;
      ST_EXCITE: state_nx = ST_MAC;
      ST_MAC:    if (mac_idx == IDX_W'(ORDER - 1)) state_nx = ST_SAT;
`ifdef LPC_SYNTH_DEEMPH_EN
      ST_SAT:    state_nx = ST_DEEMPH;
`else
      ST_SAT:    state_nx = ST_OUT;
`endif
      ST_DEEMPH: state_nx = ST_OUT;
      ST_OUT:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Control decodes and STATUS image.
  always_comb begin
    start_c  = 1'b0;
    step_c   = 1'b0;
    mac_c    = 1'b0;
    out_c    = 1'b0;
    drop_c   = 1'b0;
    status_c = '0;
    start_c  = (state == ST_IDLE) && v;
    drop_c   = (state != ST_IDLE) && v;
    step_c   = (state == ST_EXCITE);
    mac_c    = (state == ST_MAC);
    out_c    = (state == ST_OUT);
    status_c.overrun       = overrun;
    status_c.busy          = (state != ST_IDLE);
    status_c.voiced_active = act_voiced;
  end

  lpc_excitation_gen u_exc (
    .clk        (clk),
    .rst        (rst),
    .step       (step_c),
    .voiced     (act_voiced),
    .freq_count (act_fc),
    .gain       (gain),
    .e          (e)
  );

  // MAC datapath: first tap seeds the accumulator with the scaled excitation.
  always_comb begin
    prod_c     = 32'(a_act[mac_idx]) * 32'(hist[mac_idx]);
    acc_base_c = (mac_idx == '0) ? (ACC_W'(e) <<< COEF_FRAC) : acc;
    acc_nx_c   = acc_base_c - ACC_W'(prod_c);
    round_c    = (acc + ACC_W'(ONE_Q12 >>> 1)) >>> COEF_FRAC;
    sat_val_c  = sat16(round_c);
  end

`ifdef LPC_SYNTH_DEEMPH_EN
  logic signed [DW-1:0]    d_prev;
  logic signed [ACC_W-1:0] deemph_sum_c;

  always_comb begin
    deemph_sum_c = ACC_W'(y_syn) + ((ACC_W'(d_prev) * ACC_W'(15)) >>> 4);
    y_out_c      = sat16(deemph_sum_c);
    yv_set_c     = (state == ST_DEEMPH);
  end

  // De-emphasis memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          d_prev <= '0;
    else if (yv_set_c) d_prev <= y_out_c;
  end
`else
  always_comb begin
    y_out_c  = sat_val_c;
    yv_set_c = (state == ST_SAT);
  end
`endif

  // Frame parameters: PENDING on coef_v, ACTIVE only when a sample starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < ORDER; k++) begin
        a_pend[k] <= '0;
        a_act[k]  <= '0;
      end
      pend_voiced <= 1'b0;
      act_voiced  <= 1'b0;
      pend_fc     <= '0;
      act_fc      <= '0;
    end else begin
      if (coef_v) begin
        for (int k = 0; k < ORDER; k++) a_pend[k] <= a_in[k];
        pend_voiced <= voiced;
        pend_fc     <= freq_count;
      end
      if (start_c) begin
        for (int k = 0; k < ORDER; k++) a_act[k] <= a_pend[k];
        act_voiced <= pend_voiced;
        act_fc     <= pend_fc;
      end
    end
  end

  // Accumulator, tap index, raw synthesis sample and output history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_idx <= '0;
      acc     <= '0;
      y_syn   <= '0;
      for (int k = 0; k < ORDER; k++) hist[k] <= '0;
    end else begin
      if (step_c)     mac_idx <= '0;
      else if (mac_c) mac_idx <= mac_idx + IDX_W'(1);
      if (mac_c) acc <= acc_nx_c;
      if (state == ST_SAT) y_syn <= sat_val_c;
      if (out_c) begin
        hist[0] <= y_syn;
        for (int k = 1; k < ORDER; k++) hist[k] <= hist[k-1];
      end
    end
  end

  // Sample output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y  <= '0;
      yv <= 1'b0;
    end else begin
      yv <= yv_set_c;
      if (yv_set_c) y <= y_out_c;
    end
  end

  // Register slave; a new overrun takes priority over the read-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gain     <= '0;
      overrun  <= 1'b0;
      readdata <= '0;
    end else begin
      if (write && (address == REG_GAIN)) gain <= writedata;
      if (drop_c)
        overrun <= 1'b1;
      else if (read && (address == REG_STATUS))
        overrun <= 1'b0;
      if (read) begin
        case (address)
          REG_GAIN:   readdata <= gain;
          REG_STATUS: readdata <= status_c;
          default:    readdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpc_synth.sv
// Scoreboard bench for lpc_synth: randomized and directed frames checked
// against a behavioural model of excitation + all-pole synthesis.
module tb_lpc_synth;

`ifdef LPC_SYNTH_DEEMPH_EN
  localparam int LAT = 14;
`else
  localparam int LAT = 13;
`endif

  logic               clk, rst;
  logic signed [15:0] a_drv [10];
  logic               voiced, coef_v, v;
  logic [15:0]        freq_count;
  logic signed [15:0] y;
  logic               yv;
  logic [15:0]        address, writedata, readdata;
  logic               read, write;

  lpc_synth dut (
    .clk(clk), .rst(rst),
    .A1(a_drv[0]), .A2(a_drv[1]), .A3(a_drv[2]), .A4(a_drv[3]), .A5(a_drv[4]),
    .A6(a_drv[5]), .A7(a_drv[6]), .A8(a_drv[7]), .A9(a_drv[8]), .A10(a_drv[9]),
    .voiced(voiced), .freq_count(freq_count), .coef_v(coef_v), .v(v),
    .y(y), .yv(yv),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct { longint y; int due; } exp_t;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state.
  int          m_gain;
  int          m_pa [10];
  int          m_aa [10];
  longint      m_hist [10];
  bit          m_pv, m_av;
  int          m_pfc, m_afc;
  int          m_n, m_next_pulse;
  logic [15:0] m_lfsr;
  longint      m_dprev;

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic longint sat16m(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  task automatic model_reset();
    m_gain = 0;
    for (int i = 0; i < 10; i++) begin
      m_pa[i] = 0; m_aa[i] = 0; m_hist[i] = 0;
    end
    m_pv = 0; m_av = 0; m_pfc = 0; m_afc = 0;
    m_n = 0; m_next_pulse = 0;
    m_lfsr = 16'hACE1;
    m_dprev = 0;
  endtask

  // One accepted sample: pulses fall on sample indices spaced by the period.
  task automatic model_sample(output longint yo);
    longint ex, acc, yr;
    int p;
    for (int i = 0; i < 10; i++) m_aa[i] = m_pa[i];
    m_av  = m_pv;
    m_afc = m_pfc;
    if (m_av) begin
      p = (m_afc < 20) ? 20 : m_afc;
      if (m_n == m_next_pulse) begin
        ex = (m_gain > 32767) ? 32767 : longint'(m_gain);
        m_next_pulse = m_n + p;
      end else begin
        ex = 0;
      end
    end else begin
      ex = (longint'($signed(m_lfsr)) * longint'(m_gain)) >>> 18;
      m_next_pulse = m_n + 1;
    end
    m_lfsr = lfsr_adv(m_lfsr);
    acc = ex * 4096;
    for (int k = 0; k < 10; k++) acc = acc - longint'(m_aa[k]) * m_hist[k];
    yr = sat16m((acc + 2048) >>> 12);
    for (int k = 9; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = yr;
    m_n++;
`ifdef LPC_SYNTH_DEEMPH_EN
    yo = sat16m(yr + ((15 * m_dprev) >>> 4));
    m_dprev = yo;
`else
    yo = yr;
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reg_write(input logic [15:0] a, input logic [15:0] d);
    address = a; writedata = d; write = 1'b1;
    tick(1);
    write = 1'b0;
    if (a == 16'd0) m_gain = int'(d);
  endtask

  task automatic reg_read(input string name, input logic [15:0] a, input longint expv);
    address = a; read = 1'b1;
    tick(1);
    read = 1'b0;
    chk(name, longint'(readdata), expv);
  endtask

  task automatic load_coefs(input int a[10], input bit vo, input int fc);
    for (int i = 0; i < 10; i++) begin
      a_drv[i] = 16'(a[i]);
      m_pa[i]  = a[i];
    end
    voiced = vo; freq_count = 16'(fc); coef_v = 1'b1;
    tick(1);
    coef_v = 1'b0;
    m_pv = vo; m_pfc = fc;
  endtask

  task automatic fire_v();
    longint ye;
    model_sample(ye);
    exp_q.push_back('{y: ye, due: cyc + LAT});
    v = 1'b1;
    tick(1);
    v = 1'b0;
  endtask

  task automatic sample();
    fire_v();
    tick(LAT + 1);
  endtask

  // New frame loaded while the current sample is still in the MAC.
  task automatic sample_mid(input int a[10], input bit vo, input int fc);
    fire_v();
    tick(4);
    load_coefs(a, vo, fc);
    tick(LAT - 4);
  endtask

  task automatic rand_coefs(output int a[10]);
    for (int i = 0; i < 10; i++) a[i] = int'($urandom_range(0, 1200)) - 600;
  endtask

  // Monitor: every yv pops one expectation; missing yv is caught by due cycle.
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (yv) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_yv: got y=%0d with no sample pending (cycle %0d)", y, cyc);
          end else begin
            ex = exp_q.pop_front();
            chk("y", longint'(y), ex.y);
            chk("yv_latency", longint'(cyc), longint'(ex.due));
          end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
          n_checks++;
          $display("FAIL yv_timeout: got no yv expected y=%0d by cycle %0d", exp_q[0].y, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    int za [10];
    int a  [10];
    int b  [10];
    bit vo;
    int fc;
    longint av;

    for (int i = 0; i < 10; i++) begin za[i] = 0; a_drv[i] = '0; end
    voiced = 0; coef_v = 0; v = 0; freq_count = '0;
    address = '0; writedata = '0; read = 0; write = 0;
    rst = 1'b0;
    model_reset();
    tick(3);
    chk("reset_y", longint'(y), 0);
    chk("reset_yv", longint'(yv), 0);
    chk("reset_readdata", longint'(readdata), 0);
    rst = 1'b1;
    tick(2);
    reg_read("status_after_reset", 16'd1, 0);
    reg_read("gain_after_reset", 16'd0, 0);

    // Voiced pulse train, flat filter.
    reg_write(16'd0, 16'd1000);
    load_coefs(za, 1'b1, 40);
    repeat (100) sample();
    reg_read("status_voiced", 16'd1, 1);

    // Register map corners.
    reg_write(16'd1, 16'hFFFF);
    reg_read("gain_readback", 16'd0, 1000);
    reg_read("status_after_ro_write", 16'd1, 1);
    reg_read("unmapped_read", 16'd7, 0);

    // Single-pole decay, counter restarted by a silent unvoiced sample.
    reg_write(16'd0, 16'd0);
    load_coefs(za, 1'b0, 200);
    sample();
    reg_write(16'd0, 16'd1000);
    a = za; a[0] = -2048;
    load_coefs(a, 1'b1, 200);
    repeat (12) sample();

    // Unstable pole drives saturation.
    reg_write(16'd0, 16'd0);
    load_coefs(za, 1'b0, 200);
    sample();
    reg_write(16'd0, 16'd30000);
    a = za; a[0] = -8192;
    load_coefs(a, 1'b1, 200);
    repeat (8) sample();

    // Coefficient change while busy takes effect one sample later.
    reg_write(16'd0, 16'd1000);
    a = za; a[0] = -2048;
    load_coefs(a, 1'b1, 20);
    sample();
    b = za; b[0] = 1024;
    sample_mid(b, 1'b1, 20);
    sample();
    sample();

    // Overrun: dropped strobe, sticky flag, read-clear.
    av = m_av ? 1 : 0;
    fire_v();
    tick(3);
    v = 1'b1; tick(1); v = 1'b0;
    tick(LAT);
    reg_read("overrun_set", 16'd1, 4 + av);
    reg_read("overrun_cleared", 16'd1, av);

    // Overrun arriving on the same cycle as the clearing read.
    fire_v();
    tick(3);
    v = 1'b1; address = 16'd1; read = 1'b1;
    tick(1);
    v = 1'b0; read = 1'b0;
    chk("status_busy_snapshot", longint'(readdata), 2 + av);
    tick(LAT);
    reg_read("overrun_set_wins", 16'd1, 4 + av);
    reg_read("overrun_cleared2", 16'd1, av);

    // Randomized frames, including unvoiced noise and short pitch clamp.
    repeat (50) begin
      rand_coefs(a);
      vo = 1'($urandom_range(0, 1));
      fc = int'($urandom_range(0, 60));
      if ($urandom_range(0, 3) == 0) reg_write(16'd0, 16'($urandom_range(0, 20000)));
      if ($urandom_range(0, 2) == 0) begin
        sample_mid(a, vo, fc);
      end else begin
        load_coefs(a, vo, fc);
        sample();
      end
      tick(int'($urandom_range(0, 2)));
    end

    // Reset in the middle of the MAC.
    reg_write(16'd0, 16'd1234);
    reg_read("gain_pre_reset", 16'd0, 1234);
    v = 1'b1; tick(1); v = 1'b0;
    tick(5);
    rst = 1'b0;
    #1;
    chk("midreset_y", longint'(y), 0);
    chk("midreset_yv", longint'(yv), 0);
    chk("midreset_readdata", longint'(readdata), 0);
    tick(5);
    chk("midreset_yv_held", longint'(yv), 0);
    rst = 1'b1;
    model_reset();
    tick(LAT + 10);
    reg_read("status_post_reset", 16'd1, 0);
    reg_read("gain_post_reset", 16'd0, 0);

    tick(LAT + 2);
    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
